// File: rtl/adder_pkg.sv
// Shared constants, types and configuration check for the pipelined add/subtract unit.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Narrow per-stage control that travels with each operation. The wide
    // operand/partial-sum fields scale with WIDTH, so the top wraps this in
    // its own payload struct.
    typedef struct packed {
        logic carry;      // carry out of the most recently computed chunk
        logic op_sub;     // operation kind, kept for visibility down the pipe
        logic a_msb;      // sign of operand A
        logic b_eff_msb;  // sign of the effective (possibly inverted) operand B
    } stage_ctrl_t;

    // True when WIDTH splits evenly into STAGES chunks of at least one bit.
    function automatic bit cfg_ok(int unsigned width, int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational WIDTH-bit adder slice with carry in and carry out.
module add_chunk #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one CHUNK-wide carry-chained slice per stage,
// valid/ready handshake on both sides, one operation per cycle.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $fatal(1, "pipe_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // a_rem/b_rem keep the full operands; only chunks at and above the current
    // stage are still needed. psum fills in one chunk per stage from the bottom.
    typedef struct packed {
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] psum;
        stage_ctrl_t      ctrl;
    } payload_t;

    payload_t          in_payload;
    payload_t          res    [STAGES];
    payload_t          pipe_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic              advance;
    logic              in_fire;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign out_valid = valid_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance && !rst;
    assign in_fire   = in_valid && in_ready;

    // Subtraction becomes A + ~B + !cin, so every stage is a plain adder.
    always_comb begin
        in_payload                = '0;
        in_payload.a_rem          = ain;
        in_payload.b_rem          = op_sub ? ~bin : bin;
        in_payload.psum           = '0;
        in_payload.ctrl.carry     = op_sub ? ~cin : cin;
        in_payload.ctrl.op_sub    = op_sub;
        in_payload.ctrl.a_msb     = ain[WIDTH-1];
        in_payload.ctrl.b_eff_msb = op_sub ^ bin[WIDTH-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        payload_t         src;
        payload_t         stage_out;
        logic [CHUNK-1:0] s_chunk;
        logic             c_out;

        if (k == 0) begin : g_head
            assign src = in_payload;
        end else begin : g_body
            assign src = pipe_q[k-1];
        end

        add_chunk #(
            .WIDTH(CHUNK)
        ) u_add (
            .a (src.a_rem[k*CHUNK +: CHUNK]),
            .b (src.b_rem[k*CHUNK +: CHUNK]),
            .ci(src.ctrl.carry),
            .s (s_chunk),
            .co(c_out)
        );

        // Insert this stage's sum chunk and pass its carry on to the next stage.
        always_comb begin
            stage_out            = src;
            stage_out.psum       = src.psum | (WIDTH'(s_chunk) << (k * CHUNK));
            stage_out.ctrl.carry = c_out;
        end

        assign res[k] = stage_out;
    end

    // Next valid vector: new beat enters stage 0, everything else shifts down.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_fire;
        for (int unsigned k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    // Stage valids: cleared by reset, shifted only on advance so bubbles stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
        end
    end

    // Payload moves with the valids; no reset since outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        if (advance) begin
            pipe_q <= res;
        end
    end

    assign sum  = out_valid ? pipe_q[STAGES-1].psum : '0;
    assign cout = out_valid && pipe_q[STAGES-1].ctrl.carry;
    assign ovf  = out_valid
               && (pipe_q[STAGES-1].ctrl.a_msb == pipe_q[STAGES-1].ctrl.b_eff_msb)
               && (pipe_q[STAGES-1].psum[WIDTH-1] != pipe_q[STAGES-1].ctrl.a_msb);

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three configurations (32/4, 8/1, 8/8) share one stimulus
// stream; each has its own scoreboard fed by an arithmetic reference model.
module tb_pipe_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] ain = '0;
    logic [31:0] bin = '0;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [31:0] sum [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic int unsigned cfg_w(int g);
        return (g == 0) ? 32 : 8;
    endfunction

    function automatic int unsigned cfg_lat(int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    endfunction

    // Reference: plain integer arithmetic on w-bit unsigned / signed values.
    function automatic res_t model(int unsigned w, logic [31:0] a, logic [31:0] b,
                                   logic c, logic sub);
        longint full = longint'(1) << w;
        longint half = full / 2;
        longint ua   = longint'(a) & (full - 1);
        longint ub   = longint'(b) & (full - 1);
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sb   = (ub >= half) ? ub - full : ub;
        longint u;
        longint t;
        res_t   r;
        if (sub) begin
            u   = ua - ub - longint'(c);
            t   = sa - sb - longint'(c);
            r.c = (u >= 0);
        end else begin
            u   = ua + ub + longint'(c);
            t   = sa + sb + longint'(c);
            r.c = (u >= full);
        end
        r.s = 32'(((u % full) + full) % full);
        r.o = (t < -half) || (t >= half);
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = cfg_w(g);
        localparam int unsigned S = cfg_lat(g);
        logic [W-1:0] s_w;
        res_t         q[$];

        pipe_adder #(
            .WIDTH (W),
            .STAGES(S)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .ain      (ain[W-1:0]),
            .bin      (bin[W-1:0]),
            .cin      (cin),
            .op_sub   (op_sub),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .sum      (s_w),
            .cout     (cout[g]),
            .ovf      (ovf[g])
        );

        assign sum[g] = 32'(s_w);

        // Scoreboard: every delivered result must be the oldest outstanding one.
        always @(negedge clk) begin
            res_t e;
            res_t got;
            got = '{s: sum[g], c: cout[g], o: ovf[g]};
            if (out_valid[g] === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb%0d_spurious: got sum=%h cout=%b ovf=%b, expected no result",
                             g, got.s, got.c, got.o);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sb%0d_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 g, got.s, got.c, got.o, e.s, e.c, e.o);
                    end
                end
            end
            if (in_valid && in_ready[g] === 1'b1) q.push_back(model(W, ain, bin, cin, op_sub));
            if (rst) q.delete();
        end
    end

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ain = $urandom();
            bin = $urandom();
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (in_ready[g] !== 1'b0 || out_valid[g] !== 1'b0 || sum[g] !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_hold[%0d]: in_ready=%b out_valid=%b sum=%h, expected 0 0 00000000",
                             g, in_ready[g], out_valid[g], sum[g]);
                end
            end
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || cout[g] !== 1'b0 || ovf[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: in_ready=%b out_valid=%b cout=%b ovf=%b, expected 1 0 0 0",
                         g, in_ready[g], out_valid[g], cout[g], ovf[g]);
            end
        end
    endtask

    // Single operation into an idle pipe; checks exact latency and result.
    task automatic test_op(string name, logic [31:0] a, logic [31:0] b, logic c, logic sub,
                           logic [31:0] exp_s, logic exp_c, logic exp_o);
        res_t exp;
        res_t got;
        @(posedge clk); #1;
        ain = a; bin = b; cin = c; op_sub = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ain      = $urandom();
        bin      = $urandom();
        cin      = 1'($urandom_range(0, 1));
        op_sub   = 1'($urandom_range(0, 1));
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (out_valid[g] !== (n == cfg_lat(g))) begin
                    errors++;
                    $display("FAIL %s_latency[%0d] cycle %0d: out_valid=%b, expected %b",
                             name, g, n, out_valid[g], (n == cfg_lat(g)));
                end
                if (n == cfg_lat(g)) begin
                    exp = (g == 0) ? '{s: exp_s, c: exp_c, o: exp_o} : model(8, a, b, c, sub);
                    got = '{s: sum[g], c: cout[g], o: ovf[g]};
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL %s_value[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 name, g, got.s, got.c, got.o, exp.s, exp.c, exp.o);
                    end
                end
            end
        end
    endtask

    // Random stream with a forced 3-cycle stall, then random out_ready.
    task automatic test_back_pressure();
        int          accepted = 0;
        int          cyc = 0;
        logic [2:0]  prev_stall = '0;
        logic [2:0]  prev_cout = '0;
        logic [2:0]  prev_ovf = '0;
        logic [31:0] prev_sum [3];
        @(posedge clk); #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ain = $urandom(); bin = $urandom();
        cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
        while (cyc < 300 && (accepted < 16 || out_valid !== 3'b000)) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (prev_stall[g]) begin
                    checks++;
                    if (out_valid[g] !== 1'b1 || sum[g] !== prev_sum[g] ||
                        cout[g] !== prev_cout[g] || ovf[g] !== prev_ovf[g]) begin
                        errors++;
                        $display("FAIL stall_hold[%0d]: out_valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                                 g, out_valid[g], sum[g], cout[g], ovf[g],
                                 prev_sum[g], prev_cout[g], prev_ovf[g]);
                    end
                end
                if (out_valid[g] && !out_ready) begin
                    checks++;
                    if (in_ready[g] !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready[%0d]: in_ready=%b, expected 0", g, in_ready[g]);
                    end
                end
                prev_stall[g] = out_valid[g] && !out_ready;
                prev_sum[g]   = sum[g];
                prev_cout[g]  = cout[g];
                prev_ovf[g]   = ovf[g];
            end
            if (in_valid && in_ready[0]) accepted++;
            @(posedge clk); #1;
            cyc++;
            if (accepted >= 16) in_valid = 1'b0;
            ain = $urandom(); bin = $urandom();
            cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
            if (cyc >= 6 && cyc <= 8) out_ready = 1'b0;
            else if (cyc < 6)         out_ready = 1'b1;
            else                      out_ready = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (accepted != 16 || out_valid !== 3'b000) begin
            errors++;
            $display("FAIL back_pressure_done: accepted=%0d out_valid=%b, expected 16 000",
                     accepted, out_valid);
        end
    endtask

    // Three ops in flight, one-cycle reset: nothing may emerge afterwards.
    task automatic test_midflight_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            ain = $urandom(); bin = $urandom();
            cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (out_valid[g] !== 1'b0 || sum[g] !== 32'd0) begin
                    errors++;
                    $display("FAIL midflight_reset[%0d] cycle %0d: out_valid=%b sum=%h, expected 0 00000000",
                             g, n, out_valid[g], sum[g]);
                end
            end
        end
    endtask

    task automatic test_drain();
        int qs [3];
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        qs[0] = g_dut[0].q.size();
        qs[1] = g_dut[1].q.size();
        qs[2] = g_dut[2].q.size();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (qs[g] != 0 || out_valid[g] !== 1'b0) begin
                errors++;
                $display("FAIL drain[%0d]: outstanding=%0d out_valid=%b, expected 0 0",
                         g, qs[g], out_valid[g]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_op("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_op("ovf_pos",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_op("ovf_neg",      32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        test_op("sub_5_7",      32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        test_op("sub_7_5",      32'd7,         32'd5,         1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        test_back_pressure();
        test_midflight_reset();
        test_back_pressure();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
